// File: rtl/carousel_rotator.sv
// carousel_rotator: gathers one word per lane, then drains the set rotated by a per-round amount.
// Defining CAROUSEL_ROUND_CNT_EN adds the ROUND_CNT_WIDTH parameter and the round_count output.
module carousel_rotator #(
    parameter int unsigned NUM_CH          = 4,
    parameter int unsigned DATA_WIDTH      = 8,
`ifdef CAROUSEL_ROUND_CNT_EN
    parameter int unsigned ROUND_CNT_WIDTH = 16,
`endif
    parameter int unsigned ROT_W           = $clog2(NUM_CH)
) (
    input  logic                               clk,
    input  logic                               rst,
`ifdef CAROUSEL_ROUND_CNT_EN
    output logic [ROUND_CNT_WIDTH-1:0]         round_count,
`endif
    input  logic [NUM_CH-1:0][DATA_WIDTH-1:0]  data_in,
    input  logic [NUM_CH-1:0]                  data_in_valid,
    output logic [NUM_CH-1:0]                  data_in_ready,
    input  logic [ROT_W-1:0]                   rot_amt,
    output logic [NUM_CH-1:0][DATA_WIDTH-1:0]  data_out,
    output logic [NUM_CH-1:0]                  data_out_valid,
    input  logic [NUM_CH-1:0]                  data_out_ready
);

    localparam logic [ROT_W:0] NUM_CH_EXT = (ROT_W+1)'(NUM_CH);

    typedef enum logic {
        COLLECT  = 1'b0,
        DISPENSE = 1'b1
    } state_t;

    state_t                            state_q, state_d;
    logic [NUM_CH-1:0]                 captured_q, captured_d;
    logic [NUM_CH-1:0]                 dispensed_q, dispensed_d;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0] lane_buf_q, lane_buf_d;
    logic [ROT_W-1:0]                  rot_q, rot_d;
    logic [ROT_W-1:0]                  rot_mod;
    logic [NUM_CH-1:0]                 fire_in;
    logic [NUM_CH-1:0]                 fire_out;

    // Buffer lane feeding output lane j: (j + r) mod NUM_CH without a divider.
    function automatic logic [ROT_W-1:0] src_lane(input int j, input logic [ROT_W-1:0] r);
        logic [ROT_W:0] s;
        s = (ROT_W+1)'(j) + {1'b0, r};
        if (s >= NUM_CH_EXT) begin
            s = s - NUM_CH_EXT;
        end
        return ROT_W'(s);
    endfunction

    // Handshake outputs depend only on registered state (and reset).
    assign data_in_ready  = (!rst && state_q == COLLECT)  ? ~captured_q  : '0;
    assign data_out_valid = (!rst && state_q == DISPENSE) ? ~dispensed_q : '0;
    assign fire_in        = data_in_valid  & data_in_ready;
    assign fire_out       = data_out_valid & data_out_ready;

    // Non-power-of-two lane counts can see rot_amt >= NUM_CH; fold it back once.
    always_comb begin
        if ({1'b0, rot_amt} >= NUM_CH_EXT) begin
            rot_mod = ROT_W'({1'b0, rot_amt} - NUM_CH_EXT);
        end else begin
            rot_mod = rot_amt;
        end
    end

    always_comb begin
        for (int j = 0; j < int'(NUM_CH); j++) begin
            data_out[j] = lane_buf_q[src_lane(j, rot_q)];
        end
    end

    // Next-state logic.
    always_comb begin
        state_d     = state_q;
        captured_d  = captured_q;
        dispensed_d = dispensed_q;
        lane_buf_d  = lane_buf_q;
        rot_d       = rot_q;
        case (state_q)
            COLLECT: begin
                for (int i = 0; i < int'(NUM_CH); i++) begin
                    if (fire_in[i]) begin
                        lane_buf_d[i] = data_in[i];
                    end
                end
                captured_d = captured_q | fire_in;
                if (&captured_d) begin
                    state_d    = DISPENSE;
                    captured_d = '0;
                    rot_d      = rot_mod;
                end
            end
            DISPENSE: begin
                dispensed_d = dispensed_q | fire_out;
                if (&dispensed_d) begin
                    state_d     = COLLECT;
                    dispensed_d = '0;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= COLLECT;
            captured_q  <= '0;
            dispensed_q <= '0;
            lane_buf_q  <= '0;
            rot_q       <= '0;
        end else begin
            state_q     <= state_d;
            captured_q  <= captured_d;
            dispensed_q <= dispensed_d;
            lane_buf_q  <= lane_buf_d;
            rot_q       <= rot_d;
        end
    end

`ifdef CAROUSEL_ROUND_CNT_EN
    logic [ROUND_CNT_WIDTH-1:0] round_cnt_q;
    logic                       round_done;

    // A round completes on the DISPENSE -> COLLECT edge.
    assign round_done = (state_q == DISPENSE) && (state_d == COLLECT);

    always_ff @(posedge clk) begin
        if (rst) begin
            round_cnt_q <= '0;
        end else if (round_done) begin
            round_cnt_q <= round_cnt_q + ROUND_CNT_WIDTH'(1);
        end
    end

    assign round_count = round_cnt_q;
`endif

endmodule

// File: tb/tb_carousel_rotator.sv
// Randomised self-checking bench for carousel_rotator against a round-level reference model.
// A second 3-lane instance covers rotation folding for non-power-of-two lane counts.
module tb_carousel_rotator;

    localparam int unsigned N   = 4;
    localparam int unsigned DW  = 8;
    localparam int unsigned RW  = 2;
    localparam int unsigned N3  = 3;
`ifdef CAROUSEL_ROUND_CNT_EN
    localparam int unsigned RCW = 2;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0][DW-1:0] din, dout;
    logic [N-1:0]         din_v, din_r, dout_v, dout_r;
    logic [RW-1:0]        rot_amt;

    logic [N3-1:0][DW-1:0] din3, dout3;
    logic [N3-1:0]         din_v3, din_r3, dout_v3, dout_r3;
    logic [RW-1:0]         rot_amt3;

`ifdef CAROUSEL_ROUND_CNT_EN
    logic [RCW-1:0] round_count;
    logic [15:0]    round_count3;
`endif

    carousel_rotator #(
        .NUM_CH(N),
`ifdef CAROUSEL_ROUND_CNT_EN
        .ROUND_CNT_WIDTH(RCW),
`endif
        .DATA_WIDTH(DW)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef CAROUSEL_ROUND_CNT_EN
        .round_count(round_count),
`endif
        .data_in(din),
        .data_in_valid(din_v),
        .data_in_ready(din_r),
        .rot_amt(rot_amt),
        .data_out(dout),
        .data_out_valid(dout_v),
        .data_out_ready(dout_r)
    );

    carousel_rotator #(
        .NUM_CH(N3),
        .DATA_WIDTH(DW)
    ) dut3 (
        .clk(clk),
        .rst(rst),
`ifdef CAROUSEL_ROUND_CNT_EN
        .round_count(round_count3),
`endif
        .data_in(din3),
        .data_in_valid(din_v3),
        .data_in_ready(din_r3),
        .rot_amt(rot_amt3),
        .data_out(dout3),
        .data_out_valid(dout_v3),
        .data_out_ready(dout_r3)
    );

    int checks;
    int failures;

    // Reference model: a round is "collect a word per lane, then hand out words[(j+r)%N]".
    bit              m_collect;
    bit [N-1:0]      m_got;
    bit [N-1:0]      m_done;
    logic [DW-1:0]   m_words [N];
    int unsigned     m_rot;
    int unsigned     m_rounds;

    logic [N-1:0][DW-1:0] w, d2, rd;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_collect = 1'b1;
        m_got     = '0;
        m_done    = '0;
        m_rot     = 0;
        m_rounds  = 0;
        for (int i = 0; i < int'(N); i++) m_words[i] = '0;
    endtask

    // Called just after a rising edge: check outputs, drive inputs, advance model, wait one cycle.
    task automatic step(input logic [N-1:0] v, input logic [N-1:0][DW-1:0] d,
                        input logic [N-1:0] r, input logic [RW-1:0] ra);
        logic [N-1:0] exp_ready, exp_valid, fire_in, fire_out;
        din     = d;
        din_v   = v;
        dout_r  = r;
        rot_amt = ra;
        exp_ready = m_collect ? ~m_got : '0;
        exp_valid = m_collect ? '0 : ~m_done;
        check_eq("in_ready", 64'(din_r), 64'(exp_ready));
        check_eq("out_valid", 64'(dout_v), 64'(exp_valid));
        for (int j = 0; j < int'(N); j++) begin
            if (exp_valid[j]) begin
                check_eq($sformatf("data_out%0d", j), 64'(dout[j]),
                         64'(m_words[(j + int'(m_rot)) % int'(N)]));
            end
        end
`ifdef CAROUSEL_ROUND_CNT_EN
        check_eq("round_count", 64'(round_count), 64'(m_rounds % (1 << RCW)));
`endif
        fire_in  = v & exp_ready;
        fire_out = r & exp_valid;
        if (m_collect) begin
            for (int i = 0; i < int'(N); i++) begin
                if (fire_in[i]) m_words[i] = d[i];
            end
            m_got |= fire_in;
            if (&m_got) begin
                m_collect = 1'b0;
                m_got     = '0;
                m_rot     = int'(ra) % N;
            end
        end else begin
            m_done |= fire_out;
            if (&m_done) begin
                m_collect = 1'b1;
                m_done    = '0;
                m_rounds++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_words(output logic [N-1:0][DW-1:0] o);
        for (int i = 0; i < int'(N); i++) o[i] = DW'($urandom);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        din      = '0;
        din_v    = '0;
        dout_r   = '0;
        rot_amt  = '0;
        din3     = '0;
        din_v3   = '0;
        dout_r3  = '0;
        rot_amt3 = '0;
        model_reset();

        // Reset values while rst is held high
        @(posedge clk);
        #1;
        check_eq("rst_in_ready", 64'(din_r), 64'(0));
        check_eq("rst_out_valid", 64'(dout_v), 64'(0));
        check_eq("rst_data_out", 64'(dout), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_eq("rel_in_ready", 64'(din_r), 64'hf);

        // All lanes in one cycle, rotation 1
        w[0] = 8'hA0; w[1] = 8'hB1; w[2] = 8'hC2; w[3] = 8'hD3;
        step(4'hf, w, 4'hf, 2'd1);
        check_eq("t1_out_valid", 64'(dout_v), 64'hf);
        check_eq("t1_data_out", 64'(dout), 64'({8'hA0, 8'hD3, 8'hC2, 8'hB1}));
        step(4'h0, w, 4'hf, 2'd0);
        check_eq("t1_in_ready", 64'(din_r), 64'hf);

        // Staggered capture; lane 2 re-offered a different word after capture
        rand_words(w);
        d2    = w;
        d2[2] = ~w[2];
        step(4'b0100, w, 4'h0, 2'd0);
        check_eq("t2_ready_a", 64'(din_r), 64'b1011);
        step(4'b0000, w, 4'h0, 2'd0);
        step(4'b1101, d2, 4'h0, 2'd0);
        check_eq("t2_ready_b", 64'(din_r), 64'b0010);
        step(4'b0000, w, 4'h0, 2'd0);
        step(4'b0000, w, 4'h0, 2'd0);
        step(4'b0010, w, 4'h0, 2'd3);
        check_eq("t2_data_out", 64'(dout), 64'({w[2], w[1], w[0], w[3]}));

        // Staggered drain: lane 1 first, rest three cycles later
        step(4'b0000, w, 4'b0010, 2'd1);
        check_eq("t3_valid_a", 64'(dout_v), 64'b1101);
        check_eq("t3_data_hold", 64'(dout), 64'({w[2], w[1], w[0], w[3]}));
        step(4'b0000, w, 4'b0000, 2'd2);
        step(4'b0000, w, 4'b0000, 2'd0);
        check_eq("t3_ready_wait", 64'(din_r), 64'h0);
        step(4'b0000, w, 4'b1101, 2'd0);
        check_eq("t3_ready_back", 64'(din_r), 64'hf);
        check_eq("t3_valid_off", 64'(dout_v), 64'h0);

        // Reset mid-round with two lanes captured
        rand_words(rd);
        step(4'b0011, rd, 4'h0, 2'd0);
        rst   = 1'b1;
        din_v = 4'hf;
        #1;
        check_eq("t4_rst_ready", 64'(din_r), 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        model_reset();
        check_eq("t4_ready", 64'(din_r), 64'hf);
        check_eq("t4_valid", 64'(dout_v), 64'h0);
        rand_words(w);
        step(4'hf, w, 4'h0, 2'd2);
        check_eq("t4_data_out", 64'(dout), 64'({w[1], w[0], w[3], w[2]}));
        step(4'h0, w, 4'hf, 2'd0);

        // Randomised traffic
        for (int c = 0; c < 600; c++) begin
            rand_words(rd);
            step(N'($urandom), rd, N'($urandom), RW'($urandom));
        end

        // Drain to a clean boundary, then five back-to-back rounds
        for (int c = 0; c < 4; c++) begin
            rand_words(rd);
            step(m_collect ? 4'hf : 4'h0, rd, m_collect ? 4'h0 : 4'hf, RW'($urandom));
        end
        for (int c = 0; c < 10; c++) begin
            rand_words(rd);
            step(4'hf, rd, 4'hf, RW'($urandom));
        end

        // Three-lane instance: rot_amt 3 folds to 0, then rotation 2
        din3     = {8'h33, 8'h22, 8'h11};
        din_v3   = 3'b111;
        rot_amt3 = 2'd3;
        dout_r3  = 3'b111;
        @(posedge clk);
        #1;
        din_v3 = 3'b000;
        check_eq("n3_valid", 64'(dout_v3), 64'b111);
        check_eq("n3_rot3", 64'(dout3), 64'({8'h33, 8'h22, 8'h11}));
        check_eq("n3_ready_low", 64'(din_r3), 64'h0);
        @(posedge clk);
        #1;
        check_eq("n3_ready", 64'(din_r3), 64'b111);
        din3     = {8'h66, 8'h55, 8'h44};
        din_v3   = 3'b111;
        rot_amt3 = 2'd2;
        @(posedge clk);
        #1;
        din_v3 = 3'b000;
        check_eq("n3_rot2", 64'(dout3), 64'({8'h55, 8'h44, 8'h66}));
        @(posedge clk);
        #1;
        check_eq("n3_valid_off", 64'(dout_v3), 64'h0);
`ifdef CAROUSEL_ROUND_CNT_EN
        check_eq("n3_round_count", 64'(round_count3), 64'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
